// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Parametrised Moore sequence detector. A serial bit stream is shifted into a
// LEN-bit history and compared against PATTERN (PATTERN[LEN-1] arrives first).
// Overlapping or non-overlapping detection is chosen at run time. Input
// sampling is gated by an enable, and an optional saturating match counter
// can be built in.
//
// Build option:
//   SEQ_DET_COUNT_EN  defined   -> match counter, clr and count_sat are built
//                     undefined -> match_count/count_sat tied to 0, clr ignored
//
// Parameters:
//   LEN      pattern length in bits (2..32)
//   PATTERN  target sequence, LEN bits
//   COUNT_W  match counter width (1..32)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   d            serial data bit
//   en           sample d on this edge when 1; otherwise all state holds
//   overlap      1 = overlapping detection, 0 = non-overlapping
//   clr          synchronous clear of the match counter (wins over increment)
//   out          registered Moore match flag, one enabled cycle per match
//   match_count  number of matches, saturating
//   count_sat    registered, high while match_count is all-ones
// -----------------------------------------------------------------------------
module seq_detector_param #(
  parameter int unsigned           LEN     = 4,
  parameter logic [LEN-1:0]        PATTERN = 4'b1011,
  parameter int unsigned           COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d,
  input  logic               en,
  input  logic               overlap,
  input  logic               clr,
  output logic               out,
  output logic [COUNT_W-1:0] match_count,
  output logic               count_sat
);

  // fill counts 0..LEN inclusive, so it needs one value beyond LEN-1.
  localparam int unsigned       FILL_W   = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN);
  localparam logic [FILL_W-1:0] FILL_MIN = FILL_W'(LEN - 1);

  logic [LEN-1:0]    hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              out_q,  out_d;
  logic [LEN-1:0]    cand;
  logic              match;

  // The candidate word includes the bit being sampled now; fill must already
  // hold LEN-1 valid bits so that stale history never completes a match.
  assign cand  = {hist_q[LEN-2:0], d};
  assign match = en && (cand == PATTERN) && (fill_q >= FILL_MIN);

  // NOTE: every combinational output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    out_d  = out_q;
    if (en) begin
      hist_d = cand;
      out_d  = match;
      if (match) begin
        // Overlap keeps the matched bits as a valid prefix for the next match;
        // non-overlap discards them so LEN fresh bits are needed.
        fill_d = overlap ? FILL_MAX : '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

`ifdef SEQ_DET_COUNT_EN
  logic [COUNT_W-1:0] count_q, count_d;
  logic               sat_q,   sat_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (match && !sat_q) begin
      count_d = count_q + COUNT_W'(1);
    end
    // Registered saturation flag tracks the value the counter is about to
    // take, so both change on the same edge.
    sat_d = (count_d == {COUNT_W{1'b1}});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign match_count = count_q;
  assign count_sat   = sat_q;
`else
  // Counter not built: clr has no function in this configuration.
  logic unused_clr;
  assign unused_clr  = clr;
  assign match_count = '0;
  assign count_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//
// Directed bench for seq_detector_param with LEN=4, PATTERN=1011. Two
// instances share all inputs: u_dut with an 8-bit counter and u_sat with a
// 2-bit counter for saturation. Counter expectations collapse to 0 when
// SEQ_DET_COUNT_EN is not defined.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

  logic       clk;
  logic       rst;
  logic       d;
  logic       en;
  logic       overlap;
  logic       clr;
  logic       out;
  logic [7:0] match_count;
  logic       count_sat;
  logic       out_s;
  logic [1:0] match_count_s;
  logic       count_sat_s;

  int n_total = 0;
  int n_bad   = 0;

  seq_detector_param #(.LEN(4), .PATTERN(4'b1011), .COUNT_W(8)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .d           (d),
    .en          (en),
    .overlap     (overlap),
    .clr         (clr),
    .out         (out),
    .match_count (match_count),
    .count_sat   (count_sat)
  );

  seq_detector_param #(.LEN(4), .PATTERN(4'b1011), .COUNT_W(2)) u_sat (
    .clk         (clk),
    .rst         (rst),
    .d           (d),
    .en          (en),
    .overlap     (overlap),
    .clr         (clr),
    .out         (out_s),
    .match_count (match_count_s),
    .count_sat   (count_sat_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected counter value given the count the model believes in.
  function automatic logic [31:0] ecnt(input int c);
`ifdef SEQ_DET_COUNT_EN
    return 32'(c);
`else
    return 32'(c * 0);
`endif
  endfunction

  function automatic logic [31:0] esat(input logic s);
`ifdef SEQ_DET_COUNT_EN
    return {31'd0, s};
`else
    return {31'd0, s & 1'b0};
`endif
  endfunction

  // Drive one bit, take one edge, sample 1 time unit later and check out.
  task automatic feed(input string tag, input logic b, input logic e, input logic exp_out);
    d  = b;
    en = e;
    @(posedge clk);
    #1;
    check(tag, {31'd0, out}, {31'd0, exp_out});
    check({tag, "_s"}, {31'd0, out_s}, {31'd0, exp_out});
  endtask

  // Asynchronous reset pulse placed mid-cycle; state must clear before any edge.
  task automatic pulse_reset(input string tag);
    #3;
    rst = 1'b0;
    #1;
    check({tag, "_out"}, {31'd0, out}, 32'd0);
    check({tag, "_cnt"}, {24'd0, match_count}, 32'd0);
    check({tag, "_sat"}, {31'd0, count_sat_s}, 32'd0);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [6:0] s2_bits = 7'b1011011;
    logic [6:0] s2_exp  = 7'b0001001;
    logic [6:0] s3_exp  = 7'b0001000;
    logic [5:0] s3b_bits = 6'b011011;
    logic [5:0] s3b_exp  = 6'b001000;
    logic [2:0] s5_bits  = 3'b011;
    logic [1:0] sat_cnt;

    rst = 1'b0; d = 1'b0; en = 1'b1; overlap = 1'b1; clr = 1'b0;

    // 1. Reset held for two edges with random data.
    for (int i = 0; i < 2; i++) begin
      d = 1'($urandom);
      @(posedge clk);
      #1;
      check("rst_out", {31'd0, out}, 32'd0);
      check("rst_cnt", {24'd0, match_count}, 32'd0);
      check("rst_sat", {31'd0, count_sat}, 32'd0);
    end
    rst = 1'b1;

    // 2. Overlapping detection: 1011011 matches after bits 4 and 7.
    overlap = 1'b1;
    for (int i = 6; i >= 0; i--) feed("ovl", s2_bits[i], 1'b1, s2_exp[i]);
    check("ovl_cnt", {24'd0, match_count}, ecnt(2));
    check("ovl_cnt_s", {30'd0, match_count_s}, ecnt(2));
    check("ovl_sat_s", {31'd0, count_sat_s}, esat(1'b0));

    // 3. Non-overlapping: only the first group matches; bit 7 would complete
    // 1011 but fill is too low. The continuation 0,1,1 completes 1,0,1,1.
    pulse_reset("rst3");
    overlap = 1'b0;
    for (int i = 6; i >= 0; i--) feed("novl", s2_bits[i], 1'b1, s3_exp[i]);
    check("novl_cnt1", {24'd0, match_count}, ecnt(1));
    for (int i = 5; i >= 0; i--) feed("novl2", s3b_bits[i], 1'b1, s3b_exp[i]);
    check("novl_cnt2", {24'd0, match_count}, ecnt(2));

    // 4. Enable gating: 1,0, three disabled toggles, then 1,1.
    pulse_reset("rst4");
    overlap = 1'b1;
    feed("en_a", 1'b1, 1'b1, 1'b0);
    feed("en_b", 1'b0, 1'b1, 1'b0);
    feed("en_off0", 1'b1, 1'b0, 1'b0);
    feed("en_off1", 1'b0, 1'b0, 1'b0);
    feed("en_off2", 1'b1, 1'b0, 1'b0);
    feed("en_c", 1'b1, 1'b1, 1'b0);
    feed("en_d", 1'b1, 1'b1, 1'b1);
    feed("en_hold0", 1'b0, 1'b0, 1'b1);
    feed("en_hold1", 1'b0, 1'b0, 1'b1);
    check("en_cnt", {24'd0, match_count}, ecnt(1));
    feed("en_fall", 1'b0, 1'b1, 1'b0);
    check("en_cnt2", {24'd0, match_count}, ecnt(1));

    // 5. Saturation of the 2-bit counter and clr beating a simultaneous match.
    pulse_reset("rst5");
    overlap = 1'b1;
    feed("sat_p0", 1'b1, 1'b1, 1'b0);
    for (int m = 1; m <= 5; m++) begin
      for (int i = 2; i >= 0; i--) feed("sat_p", s5_bits[i], 1'b1, (i == 0));
      sat_cnt = (m >= 3) ? 2'd3 : 2'(m);
      check("sat_cnt", {30'd0, match_count_s}, ecnt(int'(sat_cnt)));
      check("sat_flag", {31'd0, count_sat_s}, esat(m >= 3));
      check("sat_cnt8", {24'd0, match_count}, ecnt(m));
      check("sat_flag8", {31'd0, count_sat}, 32'd0);
    end
    feed("clr_p0", 1'b0, 1'b1, 1'b0);
    feed("clr_p1", 1'b1, 1'b1, 1'b0);
    clr = 1'b1;
    feed("clr_match", 1'b1, 1'b1, 1'b1);
    clr = 1'b0;
    check("clr_cnt_s", {30'd0, match_count_s}, 32'd0);
    check("clr_sat_s", {31'd0, count_sat_s}, 32'd0);
    check("clr_cnt8", {24'd0, match_count}, 32'd0);

    // 6. Reset while out is high, then reset mid-pattern discards 1,0,1.
    pulse_reset("rst6a");
    feed("mid_a0", 1'b1, 1'b1, 1'b0);
    feed("mid_a1", 1'b0, 1'b1, 1'b0);
    feed("mid_a2", 1'b1, 1'b1, 1'b0);
    feed("mid_a3", 1'b1, 1'b1, 1'b1);
    pulse_reset("rst6b");
    feed("mid_b0", 1'b1, 1'b1, 1'b0);
    feed("mid_b1", 1'b0, 1'b1, 1'b0);
    feed("mid_b2", 1'b1, 1'b1, 1'b0);
    pulse_reset("rst6c");
    feed("mid_c0", 1'b1, 1'b1, 1'b0);
    feed("mid_c1", 1'b0, 1'b1, 1'b0);
    feed("mid_c2", 1'b1, 1'b1, 1'b0);
    feed("mid_c3", 1'b1, 1'b1, 1'b1);
    check("mid_cnt", {24'd0, match_count}, ecnt(1));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised Moore sequence detector, the successor to the fixed-pattern single-bit detector. It compares a serial bit stream against a compile-time pattern of configurable length and supports overlapping and non-overlapping detection, selected at run time. It also gates input sampling with an enable and keeps an optional saturating match counter. It sits directly on a serial input line, after any synchroniser, and drives a one-cycle registered match flag to downstream control logic.

## Interface
- `LEN`, 4: pattern length in bits, 2..32.
- `PATTERN`, 4'b1011: target sequence, LEN bits wide; `PATTERN[LEN-1]` is the first bit received.
- `COUNT_W`, 8: width of the match counter, 1..32.
- `clk` in 1: single clock; everything updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `d` in 1: serial data bit.
- `en` in 1: `d` is sampled on an edge only when `en`=1.
- `overlap` in 1: 1 selects overlapping detection, 0 selects non-overlapping.
- `clr` in 1: synchronous clear of the match counter only.
- `out` out 1: Moore match flag.
- `match_count` out COUNT_W: number of matches detected.
- `count_sat` out 1: high while `match_count` is all-ones.

## Operation
**State**
- `hist[LEN-1:0]`: bit history.
- `fill`: number of valid history bits, 0..LEN; saturates at LEN.
- `out` register.
- Counter.
- Together these form the Moore state; `out` is a function of state only and never combinationally of `d`.

**On an edge with `en`=1**
- `cand = {hist[LEN-2:0], d}`.
- Match when `cand == PATTERN` and `fill >= LEN-1`.
- `hist <= cand`.

**Fill rules**
- Match with `overlap`=1: `fill <= LEN` (saturated); the tail of the matched bits may begin the next match.
- Match with `overlap`=0: `fill <= 0`; the next match needs LEN fresh bits.
- No match: `fill <= min(fill+1, LEN)`.

**Match flag**
- `out <= match` on every enabled edge, so `out` is high for exactly one enabled cycle per match.

**`en`=0 edge**
- `hist`, `fill`, `out` and the counter all hold.
- Consequently `out` stays high if it was already high.

**`overlap`**
- Sampled on the edge that produces the match; changing it mid-stream affects only later matches.

**Counter**
- Increments by 1 on each match.
- Saturates at 2^COUNT_W-1 and never wraps.

**`clr`**
- `clr`=1 on an edge sets the counter to 0.
- `clr` takes priority over a simultaneous match increment: the result is 0, not 1.
- `clr` does not affect `hist`, `fill` or `out`.

**Reset (`rst`=0)**
- Immediately, without waiting for an edge, forces `hist`=0, `fill`=0, `out`=0, `match_count`=0, `count_sat`=0.
- An in-flight partial match is discarded.

## Timing
- Latency: `out` rises at the edge that samples the final pattern bit and is valid for the following cycle. It falls at the next enabled edge unless another match occurs on that edge, which is possible with overlap where the pattern permits.
- `match_count` updates on the same edge as `out`.
- `count_sat` is registered and reaches its all-ones value on that same edge.
- First match after reset: earliest at the LEN-th enabled edge.
- Reset release: the first sampling edge is the first rising edge after `rst` returns high. Deassertion must meet recovery time; no internal synchroniser is provided.

## Configuration
- `SEQ_DET_COUNT_EN` defined: the counter, `clr` and `count_sat` logic are built as described above.
- `SEQ_DET_COUNT_EN` undefined:
  - `match_count` is tied to 0 and `count_sat` is tied to 0.
  - `clr` is ignored.
  - No counter flops are synthesised.
  - Detection behaviour is identical.

## Test plan
All scenarios use LEN=4, PATTERN=1011, `SEQ_DET_COUNT_EN` defined, unless stated.

1. **Reset:** hold `rst`=0 for 2 cycles with random `d` → `out`=0, `match_count`=0, `count_sat`=0 throughout.
2. **Overlapping detection:** `overlap`=1, `en`=1, `d` stream 1,0,1,1,0,1,1 → `out` high in the cycle after bit 4 and after bit 7; `match_count`=2.
3. **Non-overlapping detection:** `overlap`=0, same stream → `out` high only after bit 4; `match_count`=1. Feeding 0,1,1,0,1,1 afterwards gives a second match after the first 1,0,1,1 group.
4. **Enable gating:** stream 1,0 then 3 cycles of `en`=0 with `d` toggling, then 1,1 with `en`=1 → exactly one match. `out` holds during any `en`=0 cycles that follow the match.
5. **Saturation and clear:** COUNT_W=2, 5 overlapping matches → `match_count`=3 and `count_sat`=1 after the 3rd match, remaining 3. Asserting `clr` on the same edge as a 6th match → `match_count`=0.
6. **Reset mid-pattern:** after 1,0,1, pulse `rst` low between edges → `out` and `hist` clear immediately. A following 1 produces no match; a full 1,0,1,1 is then required.
